// File: rtl/evr_pulse_bank_if.sv
// Register-write port of the pulse bank: one-cycle strobe carrying channel, register select and data.
interface evr_pulse_bank_if #(
  parameter int CHANNELS = 4
);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic           cfgStrobe;
  logic [CHW-1:0] cfgChannel;
  logic [1:0]     cfgReg;
  logic [31:0]    cfgData;

  modport master (output cfgStrobe, output cfgChannel, output cfgReg, output cfgData);
  modport slave  (input  cfgStrobe, input  cfgChannel, input  cfgReg, input  cfgData);
endinterface

// File: rtl/evr_pulse_bank.sv
// Bank of independent trigger-selected delay/width/burst pulse generators sharing one config port.
// Outputs are registered: pulse rises T+1+D after the trigger edge sampled at T; busy rises at T+1.
module evr_pulse_bank #(
  parameter int CHANNELS      = 4,
  parameter int TRIGGERS      = 8,
  parameter int COUNTER_WIDTH = 24
) (
  input  logic                clk,
  input  logic                reset,
  evr_pulse_bank_if.slave     cfg,
  input  logic [TRIGGERS-1:0] trigger,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] busy
);
  localparam int CW   = COUNTER_WIDTH;
  localparam int CNTW = COUNTER_WIDTH + 1;
  localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, GAP} state_t;

  // Zero-extended so any 8-bit select indexes safely; selects >= TRIGGERS see a constant 0.
  logic [255:0] trig_ext;
  assign trig_ext = 256'(trigger);

  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg.cfgData;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CW-1:0]   delay_q, width_q, gap_q;
    logic [7:0]      sel_q, burst_q;
    logic            enable_q, invert_q;
    logic            wr_hit, wr_ctrl, enable_d, invert_d;
    logic            trig_sel, trig_edge;

    state_t          state_q;
    logic [CNTW-1:0] cnt_q, wdt_q, gapw_q;
    logic [7:0]      burst_left_q;
    logic            trig_d_q, raw_q, pulse_q, busy_q;

    assign wr_hit   = cfg.cfgStrobe && (cfg.cfgChannel == CHW'(c));
    assign wr_ctrl  = wr_hit && (cfg.cfgReg == 2'd3);
    // Post-write view of enable/invert so aborts and polarity react the cycle after the write.
    assign enable_d = wr_ctrl ? cfg.cfgData[8] : enable_q;
    assign invert_d = wr_ctrl ? cfg.cfgData[9] : invert_q;

    assign trig_sel  = trig_ext[sel_q];
    assign trig_edge = trig_sel && !trig_d_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        delay_q  <= '0;
        width_q  <= '0;
        gap_q    <= '0;
        sel_q    <= '0;
        burst_q  <= '0;
        enable_q <= 1'b0;
        invert_q <= 1'b0;
      end else if (wr_hit) begin
        case (cfg.cfgReg)
          2'd0: delay_q <= cfg.cfgData[CW-1:0];
          2'd1: width_q <= cfg.cfgData[CW-1:0];
          2'd2: gap_q   <= cfg.cfgData[CW-1:0];
          default: begin
            sel_q    <= cfg.cfgData[7:0];
            enable_q <= cfg.cfgData[8];
            invert_q <= cfg.cfgData[9];
            burst_q  <= cfg.cfgData[23:16];
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q      <= IDLE;
        cnt_q        <= '0;
        wdt_q        <= '0;
        gapw_q       <= '0;
        burst_left_q <= '0;
        trig_d_q     <= 1'b1;
        raw_q        <= 1'b0;
        pulse_q      <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        trig_d_q <= trig_sel;
        pulse_q  <= raw_q ^ invert_d;
        case (state_q)
          IDLE: begin
            // Start decisions use the registered (pre-write) settings.
            if (trig_edge && enable_q && (width_q != '0)) begin
              wdt_q        <= CNTW'(width_q);
              gapw_q       <= (gap_q == '0) ? CNTW'(1) : CNTW'(gap_q);
              burst_left_q <= (burst_q == 8'd0) ? 8'd1 : burst_q;
              busy_q       <= 1'b1;
              if (delay_q == '0) begin
                state_q <= HIGH;
                cnt_q   <= CNTW'(width_q);
                raw_q   <= 1'b1;
                pulse_q <= ~invert_d;
              end else begin
                state_q <= DELAY;
                cnt_q   <= CNTW'(delay_q);
              end
            end
          end
          DELAY, GAP: begin
            if (cnt_q == CNTW'(1)) begin
              state_q <= HIGH;
              cnt_q   <= wdt_q;
              raw_q   <= 1'b1;
              pulse_q <= ~invert_d;
            end else begin
              cnt_q <= cnt_q - CNTW'(1);
            end
          end
          HIGH: begin
            if (cnt_q == CNTW'(1)) begin
              raw_q   <= 1'b0;
              pulse_q <= invert_d;
              if (burst_left_q > 8'd1) begin
                burst_left_q <= burst_left_q - 8'd1;
                state_q      <= GAP;
                cnt_q        <= gapw_q;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q - CNTW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
        if (!enable_d && (state_q != IDLE)) begin
          state_q <= IDLE;
          raw_q   <= 1'b0;
          pulse_q <= invert_d;
          busy_q  <= 1'b0;
        end
      end
    end

    assign pulse[c] = pulse_q;
    assign busy[c]  = busy_q;
  end
endmodule

// File: tb/tb_evr_pulse_bank.sv
// Directed bench: a 3-channel bank for the main behaviour and a 1-channel 4-bit-counter bank for max counts.
module tb_evr_pulse_bank;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] trigger, trig2;
  logic [2:0] pulse, busy;
  logic [0:0] pulse2, busy2;
  int total = 0;
  int bad   = 0;

  evr_pulse_bank_if #(.CHANNELS(3)) cfg_a ();
  evr_pulse_bank_if #(.CHANNELS(1)) cfg_b ();

  evr_pulse_bank #(.CHANNELS(3), .TRIGGERS(8), .COUNTER_WIDTH(24)) dut (
    .clk(clk), .reset(reset), .cfg(cfg_a), .trigger(trigger), .pulse(pulse), .busy(busy));

  evr_pulse_bank #(.CHANNELS(1), .TRIGGERS(8), .COUNTER_WIDTH(4)) dut_max (
    .clk(clk), .reset(reset), .cfg(cfg_b), .trigger(trig2), .pulse(pulse2), .busy(busy2));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int which, input int ch, input logic [1:0] r, input logic [31:0] d);
    if (which == 0) begin
      cfg_a.cfgStrobe = 1'b1; cfg_a.cfgChannel = 2'(ch); cfg_a.cfgReg = r; cfg_a.cfgData = d;
    end else begin
      cfg_b.cfgStrobe = 1'b1; cfg_b.cfgChannel = 1'(ch); cfg_b.cfgReg = r; cfg_b.cfgData = d;
    end
    step();
    cfg_a.cfgStrobe = 1'b0;
    cfg_b.cfgStrobe = 1'b0;
  endtask

  // Called in cycle T (trigger already raised); checks T+1..T+n against bit t of each mask.
  task automatic run_chk(input string tag, input int ch, input int n,
                         input logic [63:0] pm, input logic [63:0] bm, input logic inv);
    for (int t = 1; t <= n; t++) begin
      step();
      if (t == 1) trigger = 8'h00;
      chk($sformatf("%s pulse T+%0d", tag, t), 32'(pulse[ch]), 32'(pm[t] ^ inv));
      chk($sformatf("%s busy T+%0d", tag, t), 32'(busy[ch]), 32'(bm[t]));
    end
  endtask

  initial begin
    reset = 1'b1;
    trigger = 8'h01;
    trig2 = 8'h00;
    cfg_a.cfgStrobe = 1'b0; cfg_a.cfgChannel = '0; cfg_a.cfgReg = '0; cfg_a.cfgData = '0;
    cfg_b.cfgStrobe = 1'b0; cfg_b.cfgChannel = '0; cfg_b.cfgReg = '0; cfg_b.cfgData = '0;
    repeat (3) step();
    chk("reset pulse", 32'(pulse), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    reset = 1'b0;
    step();
    chk("post-reset pulse", 32'(pulse), 32'h0);

    // Trigger[0] held high across reset release must never fire ch1.
    wr(0, 1, 2'd1, 32'd1);
    wr(0, 1, 2'd3, 32'h100);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("held trigger busy", 32'(busy[1]), 32'h0);
    end
    trigger = 8'h00;

    // Basic: D=5 W=3 sel=2
    wr(0, 0, 2'd0, 32'd5);
    wr(0, 0, 2'd1, 32'd3);
    wr(0, 0, 2'd3, 32'h102);
    trigger = 8'h04;
    run_chk("basic", 0, 10, 64'h1C0, 64'h1FE, 1'b0);

    // Zero delay, width 1
    wr(0, 0, 2'd0, 32'd0);
    wr(0, 0, 2'd1, 32'd1);
    trigger = 8'h04;
    run_chk("d0w1", 0, 4, 64'h2, 64'h2, 1'b0);

    // Width 0 never starts
    wr(0, 0, 2'd1, 32'd0);
    trigger = 8'h04;
    run_chk("w0", 0, 4, 64'h0, 64'h0, 1'b0);

    // Burst D=2 W=2 G=3 B=3, ignored edge at T+6, accepted edge at T+15
    wr(0, 0, 2'd0, 32'd2);
    wr(0, 0, 2'd1, 32'd2);
    wr(0, 0, 2'd2, 32'd3);
    wr(0, 0, 2'd3, 32'h0003_0102);
    trigger = 8'h04;
    for (int t = 1; t <= 15; t++) begin
      logic [63:0] pm, bm;
      pm = 64'h6318;
      bm = 64'h7FFE;
      step();
      chk($sformatf("burst pulse T+%0d", t), 32'(pulse[0]), 32'(pm[t]));
      chk($sformatf("burst busy T+%0d", t), 32'(busy[0]), 32'(bm[t]));
      if (t == 6) trigger = 8'h04;
      else trigger = 8'h00;
    end
    trigger = 8'h04;
    run_chk("burst retrig", 0, 16, 64'h6318, 64'h7FFE, 1'b0);

    // Width rewritten during DELAY only affects the next sequence
    wr(0, 0, 2'd3, 32'h102);
    trigger = 8'h04;
    step();
    trigger = 8'h00;
    wr(0, 0, 2'd1, 32'd10);
    chk("rewrite pulse T+2", 32'(pulse[0]), 32'h0);
    step();
    chk("rewrite pulse T+3", 32'(pulse[0]), 32'h1);
    step();
    chk("rewrite pulse T+4", 32'(pulse[0]), 32'h1);
    step();
    chk("rewrite pulse T+5", 32'(pulse[0]), 32'h0);
    chk("rewrite busy T+5", 32'(busy[0]), 32'h0);
    step();
    trigger = 8'h04;
    run_chk("new width", 0, 14, 64'h1FF8, 64'h1FFE, 1'b0);

    // Clearing enable during HIGH aborts on the next cycle
    trigger = 8'h04;
    step();
    trigger = 8'h00;
    step();
    step();
    chk("abort pulse T+3", 32'(pulse[0]), 32'h1);
    step();
    wr(0, 0, 2'd3, 32'h002);
    chk("abort pulse T+5", 32'(pulse[0]), 32'h0);
    chk("abort busy T+5", 32'(busy[0]), 32'h0);
    step();
    chk("abort busy T+6", 32'(busy[0]), 32'h0);

    // Invert: idle high, active low
    wr(0, 0, 2'd0, 32'd1);
    wr(0, 0, 2'd1, 32'd2);
    wr(0, 0, 2'd3, 32'h302);
    chk("invert idle", 32'(pulse[0]), 32'h1);
    trigger = 8'h04;
    run_chk("invert", 0, 5, 64'hC, 64'hE, 1'b1);

    // Reset during HIGH
    trigger = 8'h04;
    step();
    trigger = 8'h00;
    step();
    chk("pre-reset pulse", 32'(pulse[0]), 32'h0);
    reset = 1'b1;
    step();
    chk("mid reset pulse", 32'(pulse), 32'h0);
    chk("mid reset busy", 32'(busy), 32'h0);
    reset = 1'b0;
    step();

    // Writes to channel 3 (>= CHANNELS) change nothing
    wr(0, 3, 2'd1, 32'd1);
    wr(0, 3, 2'd3, 32'h100);
    trigger = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bad chan busy", 32'(busy), 32'h0);
      chk("bad chan pulse", 32'(pulse), 32'h0);
    end
    trigger = 8'h00;

    // Out-of-range select never fires; ch1 on the same edge does
    wr(0, 1, 2'd1, 32'd1);
    wr(0, 1, 2'd3, 32'h100);
    wr(0, 2, 2'd1, 32'd1);
    wr(0, 2, 2'd3, 32'h108);
    trigger = 8'hFF;
    step();
    chk("sel range pulse T+1", 32'(pulse), 32'h2);
    chk("sel range busy T+1", 32'(busy), 32'h2);
    trigger = 8'h00;
    step();
    chk("sel range pulse T+2", 32'(pulse), 32'h0);
    chk("sel range busy T+2", 32'(busy), 32'h0);

    // Max counts with 4-bit counters; upper data bits are dropped
    wr(1, 0, 2'd0, 32'h0000_00FF);
    wr(1, 0, 2'd1, 32'hFFFF_FFFF);
    wr(1, 0, 2'd3, 32'h100);
    trig2 = 8'h01;
    for (int t = 1; t <= 32; t++) begin
      logic [63:0] pm, bm;
      pm = 64'h7FFF_0000;
      bm = 64'h7FFF_FFFE;
      step();
      trig2 = 8'h00;
      chk($sformatf("max pulse T+%0d", t), 32'(pulse2[0]), 32'(pm[t]));
      chk($sformatf("max busy T+%0d", t), 32'(busy2[0]), 32'(bm[t]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
